// File: rtl/uart_pkg.sv
// Shared constants and types for the UART receive message buffer.
// Byte width, default framing constants and framing state type.
package uart_pkg;

    localparam int BYTE_W = 8;
    localparam logic [BYTE_W-1:0] DEF_TERM_BYTE = 8'h0A;
    localparam int DEF_MSG_LEN = 13;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_COLLECT
    } frame_st_e;

endpackage

// File: rtl/uart_rx_msg_buf_if.sv
// Host-facing bundle of the receive message buffer.
// The master side drives UART bytes and host controls.
interface uart_rx_msg_buf_if
    import uart_pkg::*;
#(
    parameter int ADDR_W = 4
);

    logic              rx_val;
    logic [BYTE_W-1:0] rx_data;
    logic              rd_en;
    logic              clr_ovf;
    logic [BYTE_W-1:0] rd_data;
    logic              rd_valid;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   level;
    logic              msg_done;
    logic [7:0]        msg_len;
    logic              overflow;

    modport master (
        output rx_val, rx_data, rd_en, clr_ovf,
        input  rd_data, rd_valid, empty, full,
        input  level, msg_done, msg_len, overflow
    );

    modport slave (
        input  rx_val, rx_data, rd_en, clr_ovf,
        output rd_data, rd_valid, empty, full,
        output level, msg_done, msg_len, overflow
    );

endinterface

// File: rtl/uart_rx_msg_buf_fifo.sv
// Single-clock byte FIFO with a registered read port.
// Pointers carry an extra wrap bit so level is a plain difference.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [BYTE_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level
);

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic              rd_ok;
    logic              wr_ok;

    assign level = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign rd_ok = rd_en & ~empty;
    assign wr_ok = wr_en & (~full | rd_ok);

    // Storage array; no reset needed, contents are qualified by the pointers.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
    end

    // Pointer advance and registered read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_ok;
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= mem[rd_ptr[ADDR_W-1:0]];
            end
        end
    end

endmodule

// File: rtl/uart_rx_msg_buf.sv
// Receive message collector: rx_val edge capture into a byte FIFO,
// message framing by count, terminator or idle timeout, sticky overflow.
module uart_rx_msg_buf
    import uart_pkg::*;
#(
    parameter int          DEPTH     = 16,
    parameter int          ADDR_W    = 4,
    parameter int          MSG_LEN   = DEF_MSG_LEN,
    parameter bit          USE_TERM  = 1'b0,
    parameter logic [7:0]  TERM_BYTE = DEF_TERM_BYTE,
    parameter int          IDLE_TO   = 20000
) (
    input logic              clk,
    input logic              rst,
    uart_rx_msg_buf_if.slave bus
);

    localparam int IDLE_W = (IDLE_TO > 1) ? $clog2(IDLE_TO) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST =
        IDLE_W'((IDLE_TO > 0) ? IDLE_TO - 1 : 0);

    logic              rx_val_q;
    logic              wr_req;
    logic              full;
    logic              empty;
    logic              rd_ok;
    logic              drop;
    frame_st_e         state;
    logic [7:0]        byte_cnt;
    logic [7:0]        next_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic              close_byte;
    logic              close_idle;
    logic              msg_done;
    logic [7:0]        msg_len;
    logic              overflow;

    assign wr_req   = bus.rx_val & ~rx_val_q;
    assign rd_ok    = bus.rd_en & ~empty;
    assign drop     = wr_req & full & ~rd_ok;
    assign next_cnt = (state == ST_COLLECT) ? byte_cnt + 8'd1 : 8'd1;

    assign close_byte = (next_cnt == 8'(MSG_LEN)) ||
                        (USE_TERM && (bus.rx_data == TERM_BYTE));
    assign close_idle = (IDLE_TO != 0) && (state == ST_COLLECT) &&
                        !wr_req && (idle_cnt == IDLE_LAST);

    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.msg_done = msg_done;
    assign bus.msg_len  = msg_len;
    assign bus.overflow = overflow;

    uart_byte_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_req),
        .wr_data  (bus.rx_data),
        .rd_en    (bus.rd_en),
        .rd_data  (bus.rd_data),
        .rd_valid (bus.rd_valid),
        .full     (full),
        .empty    (empty),
        .level    (bus.level)
    );

    // Delay rx_val by one cycle so only its rising edge requests a write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_val_q <= 1'b0;
        else     rx_val_q <= bus.rx_val;
    end

    // Framing: count bytes, time silence, pulse msg_done on close.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            byte_cnt <= '0;
            idle_cnt <= '0;
            msg_done <= 1'b0;
            msg_len  <= '0;
        end else begin
            msg_done <= 1'b0;
            if (wr_req) begin
                idle_cnt <= '0;
                if (close_byte) begin
                    state    <= ST_IDLE;
                    byte_cnt <= '0;
                    msg_done <= 1'b1;
                    msg_len  <= next_cnt;
                end else begin
                    state    <= ST_COLLECT;
                    byte_cnt <= next_cnt;
                end
            end else if (state == ST_COLLECT) begin
                if (close_idle) begin
                    state    <= ST_IDLE;
                    idle_cnt <= '0;
                    byte_cnt <= '0;
                    msg_done <= 1'b1;
                    msg_len  <= byte_cnt;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end
        end
    end

    // Sticky overflow; a dropped byte wins over a clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              overflow <= 1'b0;
        else if (drop)        overflow <= 1'b1;
        else if (bus.clr_ovf) overflow <= 1'b0;
    end

endmodule

// File: tb/tb_uart_rx_msg_buf.sv
// Randomised and directed bench for uart_rx_msg_buf.
// A queue-based reference model is compared against the DUT every cycle.
module tb_uart_rx_msg_buf;

    localparam int         DEPTH   = 16;
    localparam int         AW      = 4;
    localparam int         MLEN    = 13;
    localparam bit         UTERM   = 1'b1;
    localparam logic [7:0] TERM    = 8'h0A;
    localparam int         IDLE_TO = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_msg_buf_if #(.ADDR_W(AW)) bus ();

    uart_rx_msg_buf #(
        .DEPTH     (DEPTH),
        .ADDR_W    (AW),
        .MSG_LEN   (MLEN),
        .USE_TERM  (UTERM),
        .TERM_BYTE (TERM),
        .IDLE_TO   (IDLE_TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int n_done = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    // Reference model state, expressed as a byte queue and message counters.
    logic [7:0] q [$];
    bit         prev_val;
    bit         in_msg;
    int         m_cnt;
    int         m_sil;
    bit         e_valid;
    logic [7:0] e_data;
    bit         e_done;
    int         e_len;
    bit         e_ovf;

    // Advance the model at each edge, then compare all outputs just after it.
    always @(posedge clk) begin
        bit wr;
        bit rd_ok;
        bit wr_ok;
        cyc++;
        if (rst) begin
            q.delete();
            prev_val = 0; in_msg = 0; m_cnt = 0; m_sil = 0;
            e_valid = 0; e_data = 0; e_done = 0; e_len = 0; e_ovf = 0;
        end else begin
            wr    = bus.rx_val && !prev_val;
            prev_val = bus.rx_val;
            rd_ok = bus.rd_en && (q.size() > 0);
            wr_ok = wr && ((q.size() < DEPTH) || rd_ok);
            e_valid = rd_ok;
            if (rd_ok) e_data = q.pop_front();
            if (wr_ok) q.push_back(bus.rx_data);
            if (wr && !wr_ok) e_ovf = 1;
            else if (bus.clr_ovf) e_ovf = 0;
            e_done = 0;
            if (wr) begin
                m_cnt = in_msg ? m_cnt + 1 : 1;
                in_msg = 1;
                m_sil = 0;
                if (m_cnt == MLEN || (UTERM && bus.rx_data == TERM)) begin
                    e_done = 1; e_len = m_cnt; in_msg = 0;
                end
            end else if (in_msg) begin
                m_sil++;
                if (IDLE_TO != 0 && m_sil == IDLE_TO) begin
                    e_done = 1; e_len = m_cnt; in_msg = 0;
                end
            end
        end
        #1;
        if (bus.msg_done) n_done++;
        chk("rd_valid", int'(bus.rd_valid), int'(e_valid));
        chk("rd_data",  int'(bus.rd_data),  int'(e_data));
        chk("empty",    int'(bus.empty),    int'(q.size() == 0));
        chk("full",     int'(bus.full),     int'(q.size() == DEPTH));
        chk("level",    int'(bus.level),    q.size());
        chk("msg_done", int'(bus.msg_done), int'(e_done));
        chk("msg_len",  int'(bus.msg_len),  e_len);
        chk("overflow", int'(bus.overflow), int'(e_ovf));
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d);
        bus.rx_val  = 1'b1;
        bus.rx_data = d;
        @(negedge clk);
        bus.rx_val = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        bus.rd_en = 1'b1;
        idle(n);
        bus.rd_en = 1'b0;
        @(negedge clk);
    endtask

    logic [7:0] seq [13] = '{8'h4D, 8'h69, 8'h6B, 8'h72, 8'h6F, 8'h2D,
                             8'h54, 8'h61, 8'h73, 8'h61, 8'h72, 8'h69,
                             8'h6D};

    initial begin
        int d0;
        int cap;
        int delta;
        bus.rx_val  = 1'b0;
        bus.rx_data = 8'h00;
        bus.rd_en   = 1'b0;
        bus.clr_ovf = 1'b0;
        idle(3);
        chk("rst_empty", int'(bus.empty), 1);
        chk("rst_level", int'(bus.level), 0);
        chk("rst_len",   int'(bus.msg_len), 0);
        rst = 1'b0;
        idle(2);

        d0 = n_done;
        foreach (seq[i]) send_byte(seq[i]);
        chk("msg13_done", n_done - d0, 1);
        chk("msg13_len",  int'(bus.msg_len), 13);
        chk("msg13_lvl",  int'(bus.level), 13);
        chk("msg13_ovf",  int'(bus.overflow), 0);
        bus.rd_en = 1'b1;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            chk("drain_data", int'(bus.rd_data), int'(seq[i]));
        end
        bus.rd_en = 1'b0;
        @(negedge clk);
        chk("drain_empty", int'(bus.empty), 1);

        send_byte(8'h41);
        send_byte(8'h42);
        send_byte(8'h0A);
        chk("term_len", int'(bus.msg_len), 3);
        send_byte(8'h43);
        idle(120);
        chk("term_next_len", int'(bus.msg_len), 1);
        drain(4);

        send_byte(8'h11);
        send_byte(8'h22);
        bus.rx_val  = 1'b1;
        bus.rx_data = 8'h33;
        @(negedge clk);
        cap = cyc;
        bus.rx_val = 1'b0;
        delta = 9999;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.msg_done) begin
                delta = cyc - cap;
                break;
            end
        end
        chk("to_delta", delta, IDLE_TO);
        chk("to_len", int'(bus.msg_len), 3);
        d0 = n_done;
        idle(300);
        chk("to_quiet", n_done - d0, 0);
        drain(3);

        bus.rx_val  = 1'b1;
        bus.rx_data = 8'hAA;
        idle(50);
        bus.rx_val = 1'b0;
        @(negedge clk);
        chk("hold_level", int'(bus.level), 1);
        drain(1);
        idle(150);

        for (int i = 1; i <= 18; i++) send_byte(8'(8'h80 + i));
        chk("ovf_level", int'(bus.level), DEPTH);
        chk("ovf_full",  int'(bus.full), 1);
        chk("ovf_flag",  int'(bus.overflow), 1);
        bus.clr_ovf = 1'b1;
        @(negedge clk);
        bus.clr_ovf = 1'b0;
        chk("ovf_clr", int'(bus.overflow), 0);
        bus.rd_en   = 1'b1;
        bus.rx_val  = 1'b1;
        bus.rx_data = 8'hEE;
        @(negedge clk);
        bus.rd_en  = 1'b0;
        bus.rx_val = 1'b0;
        chk("rw_full_level", int'(bus.level), DEPTH);
        chk("rw_full_ovf",   int'(bus.overflow), 0);
        chk("rw_full_data",  int'(bus.rd_data), 8'h81);
        @(negedge clk);
        drain(DEPTH);
        idle(150);

        for (int i = 0; i < 5; i++) send_byte(seq[i]);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_empty", int'(bus.empty), 1);
        chk("mid_rst_level", int'(bus.level), 0);
        chk("mid_rst_len",   int'(bus.msg_len), 0);
        @(negedge clk);
        foreach (seq[i]) send_byte(seq[i]);
        chk("after_rst_len", int'(bus.msg_len), 13);
        drain(13);

        for (int i = 0; i < 4000; i++) begin
            bus.rx_val  = ($urandom_range(0, 2) == 0);
            bus.rx_data = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) bus.rx_data = TERM;
            bus.rd_en   = (i % 800 < 400) ? ($urandom_range(0, 5) == 0)
                                          : ($urandom_range(0, 1) == 0);
            bus.clr_ovf = ($urandom_range(0, 15) == 0);
            if ((i % 1000) > 850) bus.rx_val = 1'b0;
            @(negedge clk);
        end
        bus.rx_val  = 1'b0;
        bus.clr_ovf = 1'b0;
        drain(DEPTH + 2);
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_msg_buf.md
Name: uart_rx_msg_buf

Overview:
Receive-side message collector. It sits behind UART_Rx and captures each received byte on the rising edge of rx_val into a byte FIFO. It also frames the byte stream into messages, closed by byte count, terminator byte, or idle timeout. Host logic drains the FIFO through a rd_en/rd_valid port and is told when a full message has arrived.

Parameters:
- DEPTH, 16, FIFO depth in bytes; power of two, at least 2.
- ADDR_W, 4, log2(DEPTH).
- MSG_LEN, 13, byte count that closes a message; 1..255.
- USE_TERM, 0, when 1, receiving TERM_BYTE also closes a message.
- TERM_BYTE, 8'h0A, terminator value; it is stored in the FIFO like any other byte.
- IDLE_TO, 20000, clk cycles with no new byte after which a partial message closes; 0 disables the timeout.

Ports:
- clk, in, 1, system clock (same clk as UART_Rx).
- rst, in, 1, asynchronous active-high reset.
- rx_val, in, 1, byte-valid from UART_Rx; a byte is captured only on its 0->1 transition.
- rx_data, in, 8, received byte from UART_Rx; sampled in the cycle the rising edge of rx_val is detected.
- rd_en, in, 1, pop request from the host.
- clr_ovf, in, 1, clears the sticky overflow flag.
- rd_data, out, 8, popped byte.
- rd_valid, out, 1, one-cycle pulse; qualifies rd_data.
- empty, out, 1, FIFO holds 0 bytes.
- full, out, 1, FIFO holds DEPTH bytes.
- level, out, ADDR_W+1, current byte count in the FIFO.
- msg_done, out, 1, one-cycle pulse when a message closes.
- msg_len, out, 8, length of the last closed message; held until the next close.
- overflow, out, 1, sticky; set when a byte is dropped.

Behaviour:
- Reset (async, rst=1):
  - Pointers and level cleared; empty=1, full=0.
  - rd_valid=0, rd_data=0, msg_done=0, msg_len=0, overflow=0.
  - Byte counter and idle counter cleared; rx_val edge register cleared to 0.
  - Reset mid-message discards all buffered bytes and the partial count.
- Capture:
  - rx_val_q registers rx_val; wr_req = rx_val & ~rx_val_q.
  - A level held high on rx_val therefore yields exactly one write.
- Write acceptance:
  - Accepted if !full, or if full and a read is accepted in the same cycle.
  - Otherwise the byte is dropped and overflow is set.
  - A dropped byte is still counted toward message framing, so the message boundary is preserved.
- Read:
  - Accepted when rd_en & !empty.
  - rd_data and rd_valid are registered: the byte appears in the cycle after rd_en is sampled.
  - rd_en while empty is ignored (rd_valid=0, rd_data holds).
- Simultaneous read and write:
  - Level unchanged.
  - When empty, no bypass: the written byte is readable from the next cycle.
- Pointers wrap modulo DEPTH; level is computed from the pointer difference plus a wrap bit.
- Framing FSM, states IDLE and COLLECT:
  - IDLE: on wr_req, byte_cnt=1, go to COLLECT.
  - COLLECT: each wr_req increments byte_cnt and clears idle_cnt; otherwise idle_cnt increments.
  - Close conditions, checked on the incoming byte: (byte_cnt+1)==MSG_LEN, or USE_TERM and rx_data==TERM_BYTE.
  - Timeout close: IDLE_TO!=0 and idle_cnt reaches IDLE_TO-1.
  - On close: msg_done=1 for one cycle, msg_len=final count (including the closing byte), return to IDLE.
  - Count close and terminator close in the same byte produce a single msg_done.
  - MSG_LEN=1 closes on every byte directly from IDLE.
- overflow:
  - Set has priority over clr_ovf in the same cycle.
  - Otherwise clr_ovf clears it.
  - Writes continue normally after overflow.

Decomposition:
- Package uart_pkg:
  - BYTE_W=8.
  - Default TERM_BYTE and MSG_LEN constants.
  - Framing state enum {ST_IDLE, ST_COLLECT}.
- Sub-module uart_byte_fifo:
  - Synchronous single-clock FIFO owning pointers, level, full/empty and registered read.
  - Parameters DEPTH/ADDR_W.
  - Ports: clk, rst, wr_en, wr_data, rd_en, rd_data, rd_valid, full, empty, level.
- The top holds edge detection, framing FSM, idle counter and overflow.

Test Plan:
- Loopback with UART_Tx, UART_Rx and baudgen; send 13 bytes 4D 69 6B 72 6F 2D 54 61 73 61 72 69 6D, no reads, DEPTH=16 -> exactly one msg_done after the 13th byte; msg_len=13, level=13, overflow=0; then drain 13 reads -> rd_data reproduces the sequence in order, empty=1.
- Direct drive with DEPTH=4, MSG_LEN=13; 6 rx_val pulses of 01..06, no reads -> full after 4; bytes 05 and 06 dropped; overflow=1; level=4; reads return 01..04; clr_ovf -> overflow=0.
- USE_TERM=1, TERM_BYTE=0A; send 41 42 0A 43 -> msg_done after 0A with msg_len=3; 43 starts a new message (byte_cnt=1).
- IDLE_TO=100; send 3 bytes, then silence -> msg_done exactly 100 cycles after the last capture, msg_len=3; no further msg_done while idle.
- Hold rx_val high for 50 cycles with rx_data=AA -> exactly one write, level=1; with full and rd_en coincident with wr_req -> level stays DEPTH, no overflow.
- Assert rst mid-message after 5 bytes -> empty=1, level=0, msg_len=0; next 13 bytes yield msg_len=13, not 18.
